serial_shift_out: RTL and testbench
===================================

Name: serial_shift_out

Overview:
- Downstream stage of the registered shift-left-by-one block: consumes its 5-bit doubled word (Q) and shifts it out serially, MSB first, one bit per enabled clock.
- Valid/ready load handshake on the parallel side; bit-valid and end-of-word strobes on the serial side.
- Sits between the arithmetic shift stage and a serial link or LED/debug output.

Parameters:
- WIDTH, 5, parallel word width. Matches the 5-bit Q of the upstream stage. Legal range 2..16.
- CNT_W, 4, bit-counter width. Must satisfy 2^CNT_W > WIDTH (plus one if PARITY_EN is defined).

Ports:
- clock  input  1  single system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- D  input  WIDTH  parallel word from the upstream shift stage.
- load_valid  input  1  D is valid this cycle.
- load_ready  output  1  block accepts D this cycle.
- shift_en  input  1  advance serial output. When low, all serial state holds.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a data (or parity) bit this cycle.
- done  output  1  one-cycle strobe marking the last bit of a word.

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-high; the clock port is named clock and the reset port is named reset.
  - While reset is high: state=IDLE, shift register=0, counter=0, sout=0, sout_valid=0, done=0, load_ready=0.
  - On reset deassertion, load_ready rises combinationally from IDLE in the first cycle.
  - Reset mid-word aborts the word immediately; the remaining bits are discarded.
- States: IDLE and SHIFT. A PAR state exists only with PARITY_EN.
- Handshake:
  - A transfer occurs on a rising edge where load_valid && load_ready.
  - load_ready = (state==IDLE) || (state==SHIFT && last bit && shift_en). This allows back-to-back words with zero gap cycles.
  - Without a transfer, D is ignored.
- IDLE:
  - Outputs: sout_valid=0, sout=0, done=0.
  - On transfer: load D into the shift register, counter=0, go to SHIFT.
- SHIFT:
  - Register outputs: sout = shreg[WIDTH-1], sout_valid=1.
  - On each edge with shift_en=1: shift left by one, fill the LSB with 0, counter+1.
  - With shift_en=0: shreg, counter and outputs hold; sout_valid stays 1. The consumer samples only when shift_en=1.
  - Last bit is counter==WIDTH-1. done=1 in that cycle (combinational from state/counter; gated by shift_en=1).
  - At the last bit with shift_en=1: a simultaneous transfer reloads and stays in SHIFT with counter=0; otherwise go to IDLE.
- Latency:
  - A word accepted at edge N presents its MSB from edge N+1.
  - Bit k is sampled at edge N+1+k (shift_en held high).
  - A word occupies exactly WIDTH enabled cycles.
- Width rules:
  - D is taken as-is; no sign handling.
  - Upstream Q is a zero-extended L<<1, so the LSB is always 0 in normal operation. The block does not depend on this.
- Counter: never exceeds WIDTH-1 (WIDTH with PARITY_EN); no wrap in legal use.

Optional Feature:
- Macro: SERIAL_SHIFT_OUT_PARITY_EN.
- Defined:
  - After the last data bit, enter PAR for one enabled cycle.
  - sout = even parity (XOR) of the loaded word; sout_valid=1.
  - done moves to the parity cycle. load_ready in PAR follows the same last-bit rule.
  - A word occupies WIDTH+1 enabled cycles.
- Not defined: PAR state and parity logic are absent; behaviour is exactly as above.

Test Plan:
- Reset: assert reset mid-SHIFT of D=5'b10110 -> same-cycle sout=0, sout_valid=0, done=0. After release: load_ready=1, no further bits.
- Basic: D=5'b10110, load_valid for 1 cycle, shift_en=1 -> sout 1,0,1,1,0 on 5 consecutive cycles; done high only with the final 0; then IDLE, sout_valid=0.
- Back-to-back: 5'b00110 then 5'b11010, load_valid held -> 10 consecutive valid bits 0,0,1,1,0,1,1,0,1,0; no gap; done pulses at bits 5 and 10.
- Stall: D=5'b11100, shift_en low for 3 cycles after the 2nd bit -> sout holds 1 with sout_valid=1; sequence resumes 1,0,0; total 8 cycles.
- Not ready: load_valid high with D=5'b01010 during the 2nd bit of a word -> not accepted. Accepted only at the last-bit cycle.
- Parity (macro defined): D=5'b10110 -> 1,0,1,1,0 then parity 1; done on the parity bit. With macro undefined -> no 6th bit.

Source files
------------

// File: rtl/serial_shift_out.sv
// rtl/serial_shift_out.sv - MSB-first parallel-to-serial shifter with load handshake
// Optional SERIAL_SHIFT_OUT_PARITY_EN appends an even-parity bit after each word.
module serial_shift_out #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

`ifdef SERIAL_SHIFT_OUT_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             last_bit;
  logic             xfer;
`ifdef SERIAL_SHIFT_OUT_PARITY_EN
  logic             par_bit, par_next;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
`ifdef SERIAL_SHIFT_OUT_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      cnt     <= cnt_next;
`ifdef SERIAL_SHIFT_OUT_PARITY_EN
      par_bit <= par_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
    sout       = 1'b0;
    sout_valid = 1'b0;
    last_bit   = 1'b0;
`ifdef SERIAL_SHIFT_OUT_PARITY_EN
    par_next   = par_bit;
`endif

    case (state)
      SHIFT: begin
        sout       = shreg[WIDTH-1];
        sout_valid = 1'b1;
`ifndef SERIAL_SHIFT_OUT_PARITY_EN
        last_bit   = (cnt == LAST_CNT);
`endif
      end
`ifdef SERIAL_SHIFT_OUT_PARITY_EN
      PAR: begin
        sout       = par_bit;
        sout_valid = 1'b1;
        last_bit   = 1'b1;
      end
`endif
      default: ;
    endcase

    // Ready on the final enabled bit lets the next word follow with no gap.
    done       = last_bit && shift_en;
    load_ready = !reset && ((state == IDLE) || done);
    xfer       = load_valid && load_ready;

    case (state)
      SHIFT: begin
        if (shift_en) begin
          shreg_next = {shreg[WIDTH-2:0], 1'b0};
          cnt_next   = cnt + CNT_W'(1);
`ifdef SERIAL_SHIFT_OUT_PARITY_EN
          if (cnt == LAST_CNT) state_next = PAR;
`else
          if (last_bit) begin
            state_next = IDLE;
            cnt_next   = '0;
          end
`endif
        end
      end
`ifdef SERIAL_SHIFT_OUT_PARITY_EN
      PAR: begin
        if (shift_en) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
`endif
      default: ;
    endcase

    // A transfer only happens in IDLE or on the final bit, so it overrides the above.
    if (xfer) begin
      shreg_next = D;
      cnt_next   = '0;
      state_next = SHIFT;
`ifdef SERIAL_SHIFT_OUT_PARITY_EN
      par_next   = ^D;
`endif
    end
  end

endmodule

// File: tb/tb_serial_shift_out.sv
// tb/tb_serial_shift_out.sv - directed self-checking bench for serial_shift_out
module tb_serial_shift_out;
  localparam int WIDTH = 5;
`ifdef SERIAL_SHIFT_OUT_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int WL = WIDTH + PB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] d = '0;
  logic       load_valid = 1'b0;
  logic       shift_en = 1'b0;
  logic       load_ready, sout, sout_valid, done;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clock = ~clock;

  serial_shift_out #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .D(d), .load_valid(load_valid),
    .load_ready(load_ready), .shift_en(shift_en), .sout(sout),
    .sout_valid(sout_valid), .done(done)
  );

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; load_valid = 1'b0; shift_en = 1'b1;
    @(negedge clock);
    n_vec += 4;
    if (load_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b exp 0", load_ready); end
    if (sout_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", sout_valid); end
    if (sout !== 1'b0) begin n_err++; $display("FAIL rst_sout got %b exp 0", sout); end
    if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b exp 0", done); end
    next_cycle;
    reset = 1'b0;
    @(negedge clock);
    n_vec++;
    if (load_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready got %b exp 1", load_ready); end
    d = 5'b10110; load_valid = 1'b1;
    next_cycle;
    load_valid = 1'b0; d = '0;
    @(negedge clock);
    n_vec++;
    if (sout !== 1'b1 || sout_valid !== 1'b1) begin n_err++; $display("FAIL mid_bit0 got %b/%b exp 1/1", sout, sout_valid); end
    next_cycle;
    @(negedge clock);
    n_vec++;
    if (sout !== 1'b0 || sout_valid !== 1'b1) begin n_err++; $display("FAIL mid_bit1 got %b/%b exp 0/1", sout, sout_valid); end
    next_cycle;
    reset = 1'b1;
    #1;
    n_vec += 3;
    if (sout !== 1'b0) begin n_err++; $display("FAIL abort_sout got %b exp 0", sout); end
    if (sout_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid got %b exp 0", sout_valid); end
    if (done !== 1'b0) begin n_err++; $display("FAIL abort_done got %b exp 0", done); end
    next_cycle;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_vec++;
      if (sout_valid !== 1'b0 || load_ready !== 1'b1)
        begin n_err++; $display("FAIL post_abort cyc %0d valid/ready got %b/%b exp 0/1", k, sout_valid, load_ready); end
      next_cycle;
    end
  endtask

  task automatic test_basic;
    int exp_bits[$];
    exp_bits = '{1, 0, 1, 1, 0};
    if (PB == 1) exp_bits.push_back(1);
    d = 5'b10110; load_valid = 1'b1; shift_en = 1'b1;
    @(negedge clock);
    n_vec++;
    if (load_ready !== 1'b1 || sout_valid !== 1'b0)
      begin n_err++; $display("FAIL basic_idle ready/valid got %b/%b exp 1/0", load_ready, sout_valid); end
    next_cycle;
    load_valid = 1'b0; d = '0;
    for (int k = 0; k < WL; k++) begin
      @(negedge clock);
      n_vec++;
      if (sout !== exp_bits[k][0] || sout_valid !== 1'b1 || done !== (k == WL - 1))
        begin n_err++; $display("FAIL basic bit %0d sout/valid/done got %b/%b/%b exp %0d/1/%0d", k, sout, sout_valid, done, exp_bits[k], k == WL - 1); end
      next_cycle;
    end
    @(negedge clock);
    n_vec++;
    if (sout_valid !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1)
      begin n_err++; $display("FAIL basic_end valid/done/ready got %b/%b/%b exp 0/0/1", sout_valid, done, load_ready); end
    next_cycle;
  endtask

  task automatic test_back_to_back;
    int exp_bits[$];
    exp_bits = '{0, 0, 1, 1, 0};
    if (PB == 1) exp_bits.push_back(0);
    exp_bits.push_back(1); exp_bits.push_back(1); exp_bits.push_back(0);
    exp_bits.push_back(1); exp_bits.push_back(0);
    if (PB == 1) exp_bits.push_back(1);
    d = 5'b00110; load_valid = 1'b1; shift_en = 1'b1;
    next_cycle;
    d = 5'b11010;
    for (int k = 0; k < 2 * WL; k++) begin
      @(negedge clock);
      n_vec++;
      if (sout !== exp_bits[k][0] || sout_valid !== 1'b1 || done !== (k == WL - 1 || k == 2 * WL - 1))
        begin n_err++; $display("FAIL b2b bit %0d sout/valid/done got %b/%b/%b exp %0d/1/%0d", k, sout, sout_valid, done, exp_bits[k], (k == WL - 1 || k == 2 * WL - 1)); end
      next_cycle;
      if (k == WL - 1) load_valid = 1'b0;
    end
    @(negedge clock);
    n_vec++;
    if (sout_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end valid got %b exp 0", sout_valid); end
    next_cycle;
  endtask

  task automatic test_stall;
    int en_pat[$];
    int exp_bits[$];
    en_pat   = '{1, 1, 0, 0, 0, 1, 1, 1};
    exp_bits = '{1, 1, 1, 1, 1, 1, 0, 0};
    if (PB == 1) begin en_pat.push_back(1); exp_bits.push_back(1); end
    d = 5'b11100; load_valid = 1'b1; shift_en = 1'b1;
    next_cycle;
    load_valid = 1'b0; d = '0;
    for (int k = 0; k < en_pat.size(); k++) begin
      shift_en = en_pat[k][0];
      @(negedge clock);
      n_vec++;
      if (sout !== exp_bits[k][0] || sout_valid !== 1'b1 || done !== (k == en_pat.size() - 1))
        begin n_err++; $display("FAIL stall cyc %0d sout/valid/done got %b/%b/%b exp %0d/1/%0d", k, sout, sout_valid, done, exp_bits[k], k == en_pat.size() - 1); end
      next_cycle;
    end
    shift_en = 1'b1;
    @(negedge clock);
    n_vec++;
    if (sout_valid !== 1'b0) begin n_err++; $display("FAIL stall_end valid got %b exp 0", sout_valid); end
    next_cycle;
  endtask

  task automatic test_not_ready;
    int exp_a[$];
    int exp_b[$];
    exp_a = '{1, 0, 1, 1, 0};
    exp_b = '{0, 1, 0, 1, 0};
    if (PB == 1) begin exp_a.push_back(1); exp_b.push_back(0); end
    d = 5'b10110; load_valid = 1'b1; shift_en = 1'b1;
    next_cycle;
    load_valid = 1'b0; d = '0;
    for (int k = 0; k < WL; k++) begin
      if (k == 1) begin load_valid = 1'b1; d = 5'b01010; end
      @(negedge clock);
      n_vec++;
      if (load_ready !== (k == WL - 1) || sout !== exp_a[k][0])
        begin n_err++; $display("FAIL nrdy cyc %0d ready/sout got %b/%b exp %0d/%0d", k, load_ready, sout, k == WL - 1, exp_a[k]); end
      next_cycle;
    end
    load_valid = 1'b0; d = '0;
    for (int k = 0; k < WL; k++) begin
      @(negedge clock);
      n_vec++;
      if (sout !== exp_b[k][0] || sout_valid !== 1'b1 || done !== (k == WL - 1))
        begin n_err++; $display("FAIL nrdy_word2 bit %0d sout/valid/done got %b/%b/%b exp %0d/1/%0d", k, sout, sout_valid, done, exp_b[k], k == WL - 1); end
      next_cycle;
    end
    @(negedge clock);
    n_vec++;
    if (sout_valid !== 1'b0) begin n_err++; $display("FAIL nrdy_end valid got %b exp 0", sout_valid); end
    next_cycle;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_stall;
    test_not_ready;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
